rx_redundancy_filter: RTL and testbench

- Receive-side counterpart of the TX rate/segment/redundancy configuration.
- Consumes one parsed header per received frame (sequence, segment index, CRC status). Accepts the first good copy of each (seq, seg), drops redundant copies and late frames, and accumulates loss/duplicate statistics.
- Sits between the RX frame parser and the payload sink/statistics readout. Uses the same redundancy/segment_num_max encoding the TX side derives from switches[7:4].

---
 rtl/rx_pkg.sv | 34 +++
 rtl/sat_counter.sv | 53 +++++
 rtl/rx_redundancy_filter.sv | 189 ++++++++++++++++++
 tb/tb_rx_redundancy_filter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// ============================================================================
// Module : rx_pkg
// Brief  : Shared types and constants for the RX redundancy filter. The
//          redundancy / segment_num_max decode constants match the TX side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rx_pkg;

  // Default widths.
  localparam int SEQ_W_DEF = 16;
  localparam int SEG_W_DEF = 16;
  localparam int CNT_W_DEF = 32;

  // Tracking state machine encoding.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } rxf_state_e;

  // A programmed value of zero means "one" for both redundancy and
  // segment_num_max; these are the values substituted for zero.
  localparam logic [7:0] c_red_zero_as = 8'd1;
  localparam int         c_seg_zero_as = 1;

  // Effective copies-per-segment (zero decodes to one).
  function automatic logic [7:0] eff_redundancy(input logic [7:0] red);
    return (red == 8'd0) ? c_red_zero_as : red;
  endfunction

endpackage : rx_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating accumulator. Adds add_val_i when add_en_i is high,
//          holds at all-ones instead of wrapping; clr_i zeroes it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 32,
  parameter int ADD_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             add_en_i,
  input  logic [ADD_W-1:0] add_val_i,
  output logic [CNT_W-1:0] cnt_o
);

  // One spare bit above the wider operand so the carry out is never lost.
  localparam int SUM_W = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SUM_W-1:0] w_sum;

  // Widened sum; any bit above CNT_W means the result does not fit.
  always_comb begin
    w_sum = SUM_W'(cnt_q) + SUM_W'(add_val_i);
    if (|w_sum[SUM_W-1:CNT_W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = w_sum[CNT_W-1:0];
    end
  end

  // Counter register: clear has priority over accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (add_en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/rx_redundancy_filter.sv
// ============================================================================
// Module : rx_redundancy_filter
// Brief  : Accepts the first good copy of each (seq, seg), drops redundant
//          and late/malformed frames, and keeps loss/duplicate statistics.
//          Optional macro RXF_STATS_CLEAR_EN adds a stats_clear input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_redundancy_filter
  import rx_pkg::*;
#(
  parameter int SEQ_W = SEQ_W_DEF,
  parameter int SEG_W = SEG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RXF_STATS_CLEAR_EN
  input  logic             stats_clear,
`endif
  input  logic [7:0]       redundancy,
  input  logic [SEG_W-1:0] segment_num_max,
  input  logic             hdr_valid,
  input  logic [SEQ_W-1:0] hdr_seq,
  input  logic [SEG_W-1:0] hdr_seg,
  input  logic             hdr_crc_ok,
  output logic             accept,
  output logic             drop_dup,
  output logic             drop_late,
  output logic [CNT_W-1:0] unique_cnt,
  output logic [CNT_W-1:0] dup_cnt,
  output logic [CNT_W-1:0] late_cnt,
  output logic [CNT_W-1:0] crc_err_cnt,
  output logic [CNT_W-1:0] lost_seg_cnt,
  output logic [CNT_W-1:0] lost_pkt_cnt
);

  rxf_state_e       state_q, state_d;
  logic [SEQ_W-1:0] cur_seq_q;
  logic [SEG_W-1:0] last_seg_q;
  logic [SEG_W-1:0] seg_rcvd_q;
  logic [SEG_W-1:0] cfg_seg_max_q;
  logic             accept_q, drop_dup_q, drop_late_q;

  logic             w_clear;
  logic [SEG_W-1:0] w_seg_max_eff;
  logic [SEQ_W-1:0] w_dist;
  logic             w_crc_err, w_malformed, w_ok;
  logic             w_accept, w_dup, w_late, w_latch, w_seg_adv, w_new_seq;
  logic [SEG_W-1:0] w_lost_seg_add;
  logic [SEQ_W-1:0] w_lost_pkt_add;
  logic             w_unused;

`ifdef RXF_STATS_CLEAR_EN
  assign w_clear = stats_clear;
`else
  assign w_clear = 1'b0;
`endif

  // Redundancy only bounds expected duplicates; every extra copy is still
  // counted, so it does not steer any logic here.
  assign w_unused = ^eff_redundancy(redundancy);

  assign w_seg_max_eff = (segment_num_max == '0) ? SEG_W'(c_seg_zero_as) : segment_num_max;
  assign w_dist        = hdr_seq - cur_seq_q;
  assign w_crc_err     = hdr_valid & ~hdr_crc_ok;
  assign w_malformed   = hdr_valid & hdr_crc_ok & (hdr_seg >= w_seg_max_eff);
  assign w_ok          = hdr_valid & hdr_crc_ok & ~w_malformed;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: first good frame starts tracking; clear returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (w_clear) begin
      state_d = IDLE;
    end else if (w_ok && (state_q == IDLE)) begin
      state_d = TRACK;
    end
  end

  // Event classification for the current header.
  always_comb begin
    w_accept       = 1'b0;
    w_dup          = 1'b0;
    w_late         = 1'b0;
    w_latch        = 1'b0;
    w_seg_adv      = 1'b0;
    w_new_seq      = 1'b0;
    w_lost_seg_add = '0;
    w_lost_pkt_add = '0;
    if (w_malformed) begin
      w_late = 1'b1;
    end else if (w_ok) begin
      if (state_q == IDLE) begin
        w_accept = 1'b1;
        w_latch  = 1'b1;
      end else if (w_dist == '0) begin
        if (hdr_seg == last_seg_q) begin
          w_dup = 1'b1;
        end else begin
          w_accept  = 1'b1;
          w_seg_adv = 1'b1;
        end
      end else if (!w_dist[SEQ_W-1]) begin
        // Forward jump: close out the previous sequence's losses.
        w_accept       = 1'b1;
        w_latch        = 1'b1;
        w_new_seq      = 1'b1;
        w_lost_seg_add = (seg_rcvd_q >= cfg_seg_max_q) ? '0 : (cfg_seg_max_q - seg_rcvd_q);
        w_lost_pkt_add = w_dist - SEQ_W'(1);
      end else begin
        w_late = 1'b1;
      end
    end
  end

  // Registered one-cycle event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_q    <= 1'b0;
      drop_dup_q  <= 1'b0;
      drop_late_q <= 1'b0;
    end else begin
      accept_q    <= w_accept;
      drop_dup_q  <= w_dup;
      drop_late_q <= w_late;
    end
  end

  // Tracking context: re-latched on each new sequence, advanced per segment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_seq_q     <= '0;
      last_seg_q    <= '0;
      seg_rcvd_q    <= '0;
      cfg_seg_max_q <= SEG_W'(1);
    end else if (w_latch) begin
      cur_seq_q     <= hdr_seq;
      last_seg_q    <= hdr_seg;
      seg_rcvd_q    <= SEG_W'(1);
      cfg_seg_max_q <= w_seg_max_eff;
    end else if (w_seg_adv) begin
      last_seg_q <= hdr_seg;
      if (seg_rcvd_q < cfg_seg_max_q) begin
        seg_rcvd_q <= seg_rcvd_q + SEG_W'(1);
      end
    end
  end

  assign accept    = accept_q;
  assign drop_dup  = drop_dup_q;
  assign drop_late = drop_late_q;

  sat_counter #(.CNT_W(CNT_W), .ADD_W(1)) u_unique (
    .clk(clk), .rst(rst), .clr_i(w_clear), .add_en_i(w_accept),
    .add_val_i(1'b1), .cnt_o(unique_cnt));

  sat_counter #(.CNT_W(CNT_W), .ADD_W(1)) u_dup (
    .clk(clk), .rst(rst), .clr_i(w_clear), .add_en_i(w_dup),
    .add_val_i(1'b1), .cnt_o(dup_cnt));

  sat_counter #(.CNT_W(CNT_W), .ADD_W(1)) u_late (
    .clk(clk), .rst(rst), .clr_i(w_clear), .add_en_i(w_late),
    .add_val_i(1'b1), .cnt_o(late_cnt));

  sat_counter #(.CNT_W(CNT_W), .ADD_W(1)) u_crc (
    .clk(clk), .rst(rst), .clr_i(w_clear), .add_en_i(w_crc_err),
    .add_val_i(1'b1), .cnt_o(crc_err_cnt));

  sat_counter #(.CNT_W(CNT_W), .ADD_W(SEG_W)) u_lost_seg (
    .clk(clk), .rst(rst), .clr_i(w_clear), .add_en_i(w_new_seq),
    .add_val_i(w_lost_seg_add), .cnt_o(lost_seg_cnt));

  sat_counter #(.CNT_W(CNT_W), .ADD_W(SEQ_W)) u_lost_pkt (
    .clk(clk), .rst(rst), .clr_i(w_clear), .add_en_i(w_new_seq),
    .add_val_i(w_lost_pkt_add), .cnt_o(lost_pkt_cnt));

endmodule : rx_redundancy_filter

`default_nettype wire

// File: tb/tb_rx_redundancy_filter.sv
// ============================================================================
// Module : tb_rx_redundancy_filter
// Brief  : Scoreboard bench for rx_redundancy_filter, built with 4-bit
//          counters so saturation is reachable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_redundancy_filter;

  localparam int SEQ_W = 16;
  localparam int SEG_W = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       redundancy = 8'd3;
  logic [SEG_W-1:0] segment_num_max = 16'd1;
  logic             hdr_valid = 1'b0;
  logic [SEQ_W-1:0] hdr_seq = '0;
  logic [SEG_W-1:0] hdr_seg = '0;
  logic             hdr_crc_ok = 1'b0;
  logic             accept, drop_dup, drop_late;
  logic [CNT_W-1:0] unique_cnt, dup_cnt, late_cnt, crc_err_cnt, lost_seg_cnt, lost_pkt_cnt;

  rx_redundancy_filter #(.SEQ_W(SEQ_W), .SEG_W(SEG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .redundancy(redundancy), .segment_num_max(segment_num_max),
    .hdr_valid(hdr_valid), .hdr_seq(hdr_seq), .hdr_seg(hdr_seg), .hdr_crc_ok(hdr_crc_ok),
    .accept(accept), .drop_dup(drop_dup), .drop_late(drop_late),
    .unique_cnt(unique_cnt), .dup_cnt(dup_cnt), .late_cnt(late_cnt),
    .crc_err_cnt(crc_err_cnt), .lost_seg_cnt(lost_seg_cnt), .lost_pkt_cnt(lost_pkt_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pulses;   // {accept, drop_dup, drop_late}
    int         uniq, dup, late, crc, lseg, lpkt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  // Reference model state.
  logic m_track;
  int   m_cur, m_last, m_rcvd, m_cfg;
  int   m_uniq, m_dup, m_late, m_crc, m_lseg, m_lpkt;

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // Scoreboard: each expectation is popped one clock after its header.
  always @(negedge clk) begin
    if (chk_en && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks = checks + 7;
      if ({accept, drop_dup, drop_late} !== e.pulses) begin
        errors++; $display("FAIL pulses: got %b want %b", {accept, drop_dup, drop_late}, e.pulses);
      end
      if (unique_cnt !== CNT_W'(e.uniq)) begin
        errors++; $display("FAIL unique_cnt: got %0d want %0d", unique_cnt, e.uniq);
      end
      if (dup_cnt !== CNT_W'(e.dup)) begin
        errors++; $display("FAIL dup_cnt: got %0d want %0d", dup_cnt, e.dup);
      end
      if (late_cnt !== CNT_W'(e.late)) begin
        errors++; $display("FAIL late_cnt: got %0d want %0d", late_cnt, e.late);
      end
      if (crc_err_cnt !== CNT_W'(e.crc)) begin
        errors++; $display("FAIL crc_err_cnt: got %0d want %0d", crc_err_cnt, e.crc);
      end
      if (lost_seg_cnt !== CNT_W'(e.lseg)) begin
        errors++; $display("FAIL lost_seg_cnt: got %0d want %0d", lost_seg_cnt, e.lseg);
      end
      if (lost_pkt_cnt !== CNT_W'(e.lpkt)) begin
        errors++; $display("FAIL lost_pkt_cnt: got %0d want %0d", lost_pkt_cnt, e.lpkt);
      end
    end
  end

  task automatic model_reset();
    m_track = 1'b0; m_cur = 0; m_last = 0; m_rcvd = 0; m_cfg = 1;
    m_uniq = 0; m_dup = 0; m_late = 0; m_crc = 0; m_lseg = 0; m_lpkt = 0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    q.delete();
    rst = 1'b1; hdr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
  endtask

  // Drive one cycle of header inputs and push the modelled result.
  task automatic drive(input logic v, input int seq, input int seg, input logic crc);
    exp_t e;
    int   d, eff;
    @(negedge clk); #1;
    hdr_valid = v; hdr_seq = SEQ_W'(seq); hdr_seg = SEG_W'(seg); hdr_crc_ok = crc;
    e.pulses = 3'b000;
    eff = (segment_num_max == 0) ? 1 : int'(segment_num_max);
    if (v) begin
      if (!crc) begin
        m_crc = sat(m_crc + 1);
      end else if (seg >= eff) begin
        e.pulses = 3'b001; m_late = sat(m_late + 1);
      end else if (!m_track) begin
        e.pulses = 3'b100; m_uniq = sat(m_uniq + 1);
        m_track = 1'b1; m_cur = seq; m_last = seg; m_rcvd = 1; m_cfg = eff;
      end else begin
        d = (seq - m_cur) & 32'hFFFF;
        if (d == 0 && seg == m_last) begin
          e.pulses = 3'b010; m_dup = sat(m_dup + 1);
        end else if (d == 0) begin
          e.pulses = 3'b100; m_uniq = sat(m_uniq + 1);
          m_last = seg; if (m_rcvd < m_cfg) m_rcvd++;
        end else if (d < 32768) begin
          e.pulses = 3'b100; m_uniq = sat(m_uniq + 1);
          if (m_rcvd < m_cfg) m_lseg = sat(m_lseg + m_cfg - m_rcvd);
          m_lpkt = sat(m_lpkt + d - 1);
          m_cur = seq; m_last = seg; m_rcvd = 1; m_cfg = eff;
        end else begin
          e.pulses = 3'b001; m_late = sat(m_late + 1);
        end
      end
    end
    e.uniq = m_uniq; e.dup = m_dup; e.late = m_late;
    e.crc = m_crc; e.lseg = m_lseg; e.lpkt = m_lpkt;
    q.push_back(e);
  endtask

  task automatic drain();
    drive(1'b0, 0, 0, 1'b0);
    drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({accept, drop_dup, drop_late, unique_cnt, dup_cnt, late_cnt, crc_err_cnt,
         lost_seg_cnt, lost_pkt_cnt} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero acc=%b uniq=%0d dup=%0d", accept, unique_cnt, dup_cnt);
    end
    do_reset();
  endtask

  task automatic test_redundant_copies();
    do_reset();
    redundancy = 8'd3; segment_num_max = 16'd1;
    for (int i = 0; i < 6; i++) drive(1'b1, i / 3, 0, 1'b1);
    drain();
    checks++;
    if (unique_cnt !== 4'd2 || dup_cnt !== 4'd4 || lost_seg_cnt !== 4'd0 || lost_pkt_cnt !== 4'd0) begin
      errors++; $display("FAIL redundant_totals: got uniq=%0d dup=%0d want 2/4", unique_cnt, dup_cnt);
    end
  endtask

  task automatic test_lost_segments();
    int segs[4] = '{0, 1, 3, 4};
    do_reset();
    segment_num_max = 16'd5;
    foreach (segs[i]) drive(1'b1, 7, segs[i], 1'b1);
    drive(1'b1, 8, 0, 1'b1);
    drain();
    checks++;
    if (lost_seg_cnt !== 4'd1 || unique_cnt !== 4'd5) begin
      errors++; $display("FAIL lost_seg_totals: got lseg=%0d uniq=%0d want 1/5", lost_seg_cnt, unique_cnt);
    end
  endtask

  task automatic test_lost_packets_and_late();
    do_reset();
    segment_num_max = 16'd1;
    drive(1'b1, 10, 0, 1'b1);
    drive(1'b1, 14, 0, 1'b1);
    drive(1'b1, 12, 0, 1'b1);
    drain();
    checks++;
    if (lost_pkt_cnt !== 4'd3 || late_cnt !== 4'd1) begin
      errors++; $display("FAIL lost_pkt_late: got lpkt=%0d late=%0d want 3/1", lost_pkt_cnt, late_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    segment_num_max = 16'd1;
    drive(1'b1, 16'hFFFF, 0, 1'b1);
    drive(1'b1, 16'h0000, 0, 1'b1);
    drive(1'b1, 16'h8000, 0, 1'b1);
    drain();
    checks++;
    if (unique_cnt !== 4'd2 || lost_pkt_cnt !== 4'd0 || late_cnt !== 4'd1) begin
      errors++; $display("FAIL wrap_totals: got uniq=%0d lpkt=%0d late=%0d want 2/0/1", unique_cnt, lost_pkt_cnt, late_cnt);
    end
  endtask

  task automatic test_crc_and_malformed();
    do_reset();
    segment_num_max = 16'd5;
    drive(1'b1, 5, 0, 1'b0);
    drive(1'b1, 5, 0, 1'b1);
    drive(1'b1, 5, 5, 1'b1);
    segment_num_max = 16'd0;   // zero decodes to one segment
    drive(1'b1, 5, 1, 1'b1);
    drain();
    checks++;
    if (crc_err_cnt !== 4'd1 || unique_cnt !== 4'd1 || late_cnt !== 4'd2) begin
      errors++; $display("FAIL crc_malformed: got crc=%0d uniq=%0d late=%0d want 1/1/2", crc_err_cnt, unique_cnt, late_cnt);
    end
  endtask

  task automatic test_back_to_back_saturation();
    do_reset();
    segment_num_max = 16'd1;
    drive(1'b1, 3, 0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b1, 3, 0, 1'b1);
    drain();
    checks++;
    if (dup_cnt !== 4'd15) begin
      errors++; $display("FAIL dup_saturation: got %0d want 15", dup_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    segment_num_max = 16'd1;
    drive(1'b1, 1, 0, 1'b1);
    drive(1'b1, 2, 0, 1'b1);
    @(posedge clk); #2;
    chk_en = 1'b0;
    rst = 1'b1; hdr_valid = 1'b0;
    #1;
    checks++;
    if ({accept, drop_dup, drop_late, unique_cnt, dup_cnt, late_cnt, crc_err_cnt,
         lost_seg_cnt, lost_pkt_cnt} !== '0) begin
      errors++; $display("FAIL midstream_reset: got acc=%b uniq=%0d lpkt=%0d want 0", accept, unique_cnt, lost_pkt_cnt);
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    drive(1'b1, 9, 0, 1'b1);
    drain();
    checks++;
    if (unique_cnt !== 4'd1 || lost_pkt_cnt !== 4'd0) begin
      errors++; $display("FAIL after_reset: got uniq=%0d lpkt=%0d want 1/0", unique_cnt, lost_pkt_cnt);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_redundant_copies();
    test_lost_segments();
    test_lost_packets_and_late();
    test_wrap();
    test_crc_and_malformed();
    test_back_to_back_saturation();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rx_redundancy_filter

`default_nettype wire
